// File: rtl/hbc_pkg.sv
// rtl/hbc_pkg.sv - shared types and constants for the hbc two-master arbiter
package hbc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int M0 = 0;
    localparam int M1 = 1;

    localparam int DEFAULT_TIMEOUT = 4096;

    typedef struct packed {
        logic        cfg;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/hbc_rr_arb.sv
// rtl/hbc_rr_arb.sv - 2-way grant with registered last-grant pointer
module hbc_rr_arb
    import hbc_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_owner,
    output logic [1:0] o_grant
);

    logic r_last;

    // last-granted pointer; starts at m1 so m0 takes the first tie
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'(M1);
        end else if (i_update) begin
            r_last <= i_owner;
        end
    end

    // one-hot winner: single requester wins outright, ties go by mode
    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            if (RR_EN && (r_last == 1'(M0))) begin
                o_grant = 2'b10;
            end else begin
                o_grant = 2'b01;
            end
        end
    end

endmodule

// File: rtl/hbc_arbiter.sv
// rtl/hbc_arbiter.sv - shares the hbc memory/config port between two masters
module hbc_arbiter
    import hbc_pkg::*;
#(
    parameter bit RR_EN   = 1'b1,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = 13
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_valid,
    input  logic        i_m0_cfg,
    input  logic [3:0]  i_m0_wstrb,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_valid,
    input  logic        i_m1_cfg,
    input  logic [3:0]  i_m1_wstrb,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,
    output logic        o_mem_valid,
    output logic        o_cfg_access,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    req_t            r_req;
    req_t            w_m0_req;
    req_t            w_m1_req;
    logic [1:0]      r_grant;
    logic [1:0]      w_win;
    logic            r_mem_valid;
    logic            r_m0_ready;
    logic            r_m1_ready;
    logic            r_timeout;
    logic [31:0]     r_m0_rdata;
    logic [31:0]     r_m1_rdata;
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            w_accept;

    assign w_m0_req  = '{cfg: i_m0_cfg, wstrb: i_m0_wstrb, addr: i_m0_addr, wdata: i_m0_wdata};
    assign w_m1_req  = '{cfg: i_m1_cfg, wstrb: i_m1_wstrb, addr: i_m1_addr, wdata: i_m1_wdata};
    assign w_accept  = (r_state == ISSUE) && i_mem_ready;
    assign w_cnt_nxt = (r_cnt == TO_MAX) ? r_cnt : r_cnt + TO_W'(1);

    // pointer only moves on a completed transfer, so an abandoned one never counts
    hbc_rr_arb #(
        .RR_EN (RR_EN)
    ) u_rr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    ({i_m1_valid, i_m0_valid}),
        .i_update (w_accept),
        .i_owner  (r_grant[M1]),
        .o_grant  (w_win)
    );

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state: any request leaves IDLE, hbc ready ends ISSUE, RESP lasts one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_win != 2'b00) w_next = ISSUE;
            ISSUE:   if (i_mem_ready)    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // registered outputs: capture in IDLE, hold and watch in ISSUE, release in RESP
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req       <= '0;
            r_grant     <= 2'b00;
            r_mem_valid <= 1'b0;
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win != 2'b00) begin
                        r_req       <= w_win[M1] ? w_m1_req : w_m0_req;
                        r_grant     <= w_win;
                        r_mem_valid <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                ISSUE: begin
                    if (TIMEOUT != 0) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == TO_MAX) r_timeout <= 1'b1;
                    end
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_grant[M1]) begin
                            r_m1_rdata <= i_mem_rdata;
                            r_m1_ready <= 1'b1;
                        end else begin
                            r_m0_rdata <= i_mem_rdata;
                            r_m0_ready <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_m0_ready <= 1'b0;
                    r_m1_ready <= 1'b0;
                    r_grant    <= 2'b00;
                end
                default: begin
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_valid  = r_mem_valid;
    assign o_cfg_access = r_req.cfg;
    assign o_mem_wstrb  = r_req.wstrb;
    assign o_mem_addr   = r_req.addr;
    assign o_mem_wdata  = r_req.wdata;
    assign o_grant      = r_grant;
    assign o_m0_ready   = r_m0_ready;
    assign o_m1_ready   = r_m1_ready;
    assign o_m0_rdata   = r_m0_rdata;
    assign o_m1_rdata   = r_m1_rdata;
    assign o_timeout    = r_timeout;

endmodule
